data_mem_responder: RTL and testbench

Data-memory responder for the out-of-order core's load/store functional unit. It accepts `memReqStruct` requests from the memory issue path, buffers them in a small in-order queue, services each against a word-addressed data array after a fixed access latency, and returns a `memRespStruct` plus the requester's ROB tag to the complete stage. Its `req_ready` output drives `fuRdyStruct.mem` so the reservation station only issues memory ops when a queue slot is free.

---
 rtl/data_mem_pkg.sv | 19 +
 rtl/data_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - request/response structures shared by the memory FU and data_mem_responder
package data_mem_pkg;

  typedef struct packed {
    logic        valid;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] addr;
    logic [31:0] wr_data;
  } memReqStruct;

  typedef struct packed {
    logic        valid;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] rd_data;
  } memRespStruct;

endpackage

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - queued fixed-latency data-memory responder for the load/store unit
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int QDEPTH      = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  memReqStruct  req,
  input  logic [3:0]   req_tag,
  output logic         req_ready,
  output memRespStruct resp,
  output logic [3:0]   resp_tag
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [LW-1:0] LAT_LOAD = LW'(LATENCY - 1);
  localparam logic [CW-1:0] Q_FULL   = CW'(QDEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Data array, word addressed; never reset
  logic [31:0]   mem [DEPTH_WORDS];

  // Request queue storage; only the word index of the address is kept
  logic [AW-1:0] q_idx  [QDEPTH];
  logic [31:0]   q_data [QDEPTH];
  logic          q_wr   [QDEPTH];
  logic [3:0]    q_tag  [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Entry currently being serviced
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_data;
  logic          cur_wr;
  logic [3:0]    cur_tag;

  logic [1:0]    state;
  logic [LW-1:0] cnt;

  logic          push;
  logic          pop;
  logic          finish_access;
  logic [AW-1:0] req_idx;
  logic          unused_addr_bits;

  assign req_idx          = req.addr[AW+1:2];
  assign unused_addr_bits = ^{req.addr[31:AW+2], req.addr[1:0]};

  // Ready comes from the registered count only, so a full queue stays
  // not-ready in the cycle an entry pops.
  assign req_ready = (count < Q_FULL);

  // Requests with neither flag set are consumed here and never queued.
  assign push = req.valid & req_ready & (req.MemWrite | req.MemRead);
  assign pop  = (count != '0) & ((state == ST_IDLE) | (state == ST_RESP));

  assign finish_access = (state == ST_WAIT) && (cnt == '0);

  // Queue entry storage; write wins over read when both flags are set
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr]  <= req_idx;
      q_data[wr_ptr] <= req.wr_data;
      q_wr[wr_ptr]   <= req.MemWrite;
      q_tag[wr_ptr]  <= req_tag;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Capture the queue head as the in-service entry
  always_ff @(posedge clk) begin
    if (pop) begin
      cur_idx  <= q_idx[rd_ptr];
      cur_data <= q_data[rd_ptr];
      cur_wr   <= q_wr[rd_ptr];
      cur_tag  <= q_tag[rd_ptr];
    end
  end

  // Array write at the end of the access wait; a reset edge cancels it
  always_ff @(posedge clk) begin
    if (!reset && finish_access && cur_wr) begin
      mem[cur_idx] <= cur_data;
    end
  end

  // Service FSM and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      resp     <= '0;
      resp_tag <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            state <= ST_WAIT;
            cnt   <= LAT_LOAD;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state         <= ST_RESP;
            resp.valid    <= 1'b1;
            resp.MemWrite <= cur_wr;
            resp.MemRead  <= ~cur_wr;
            resp.rd_data  <= cur_wr ? 32'd0 : mem[cur_idx];
            resp_tag      <= cur_tag;
          end
        end
        ST_RESP: begin
          resp.valid <= 1'b0;
          if (count != '0) begin
            state <= ST_WAIT;
            cnt   <= LAT_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;
  import data_mem_pkg::*;

  typedef struct {
    logic [3:0]  tag;
    logic        w;
    logic        r;
    logic [31:0] data;
    int          exp_cyc;
  } exp_t;

  logic         clk;
  logic         reset;
  memReqStruct  req;
  logic [3:0]   req_tag;
  logic         req_ready;
  memRespStruct resp;
  logic [3:0]   resp_tag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_count = 0;
  int last_resp_cyc = -1;
  bit spacing_on = 0;
  bit saw_not_ready = 0;

  exp_t        exp_q[$];
  logic [31:0] model [256];

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .QDEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .resp      (resp),
    .resp_tag  (resp_tag)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on every valid pulse
  always @(negedge clk) begin
    if (!reset && resp.valid) begin
      exp_t e;
      resp_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got tag=%0d data=%h, required no response", resp_tag, resp.rd_data);
      end else begin
        e = exp_q.pop_front();
        if (resp_tag !== e.tag || resp.MemWrite !== e.w || resp.MemRead !== e.r || resp.rd_data !== e.data) begin
          errors++;
          $display("FAIL resp_fields: got tag=%0d w=%b r=%b data=%h, required tag=%0d w=%b r=%b data=%h",
                   resp_tag, resp.MemWrite, resp.MemRead, resp.rd_data, e.tag, e.w, e.r, e.data);
        end
        if (e.exp_cyc >= 0) begin
          checks++;
          if (cyc !== e.exp_cyc) begin
            errors++;
            $display("FAIL resp_latency tag=%0d: got cycle %0d, required %0d", e.tag, cyc, e.exp_cyc);
          end
        end
        if (spacing_on && last_resp_cyc >= 0) begin
          checks++;
          if (cyc - last_resp_cyc !== 3) begin
            errors++;
            $display("FAIL resp_spacing tag=%0d: got %0d cycles, required 3", e.tag, cyc - last_resp_cyc);
          end
        end
        last_resp_cyc = cyc;
      end
    end
  end

  // Drive one request (valid stays high afterwards until idle_req)
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r,
                      input logic [3:0] t, input int lat);
    int n;
    exp_t e;
    logic [7:0] idx;
    @(negedge clk);
    req.valid    = 1'b1;
    req.addr     = a;
    req.wr_data  = d;
    req.MemWrite = w;
    req.MemRead  = r;
    req_tag      = t;
    n = 0;
    while (!req_ready && n < 100) begin
      saw_not_ready = 1;
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout tag=%0d: req_ready=%b, required 1", t, req_ready);
    end
    @(posedge clk);
    #1;
    if (w | r) begin
      idx    = a[9:2];
      e.tag  = t;
      e.w    = w;
      e.r    = ~w;
      if (w) begin
        model[idx] = d;
        e.data = 32'd0;
      end else begin
        e.data = model[idx];
      end
      e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_req();
    @(negedge clk);
    req.valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || resp !== '0 || resp_tag !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b resp=%h tag=%0d, required ready=1 resp=0 tag=0",
               req_ready, resp, resp_tag);
    end
  endtask

  task automatic test_write_read();
    send(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 4'd3, 3);
    send(32'h10, 32'h0, 1'b0, 1'b1, 4'd4, 5);
    idle_req();
    drain();
  endtask

  task automatic test_back_to_back();
    int rc;
    for (int i = 0; i < 5; i++) begin
      send(32'(i * 4), 32'h1000_0000 + 32'(i * 32'h111), 1'b1, 1'b0, 4'(i), -1);
    end
    idle_req();
    drain();
    rc = resp_count;
    spacing_on    = 1;
    last_resp_cyc = -1;
    saw_not_ready = 0;
    for (int i = 0; i < 5; i++) begin
      send(32'(i * 4), 32'h0, 1'b0, 1'b1, 4'(8 + i), -1);
    end
    idle_req();
    drain();
    spacing_on = 0;
    checks++;
    if (!saw_not_ready) begin
      errors++;
      $display("FAIL backpressure_ready: req_ready never dropped, required a low phase");
    end
    checks++;
    if (resp_count - rc !== 5) begin
      errors++;
      $display("FAIL backpressure_count: got %0d responses, required 5", resp_count - rc);
    end
  endtask

  task automatic test_flags();
    int rc;
    send(32'h20, 32'h55, 1'b1, 1'b1, 4'd5, -1);
    idle_req();
    drain();
    send(32'h20, 32'h0, 1'b0, 1'b1, 4'd6, -1);
    idle_req();
    drain();
    rc = resp_count;
    send(32'h30, 32'h77, 1'b0, 1'b0, 4'd7, -1);
    idle_req();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL discard_ready: got %b, required 1", req_ready);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (resp_count !== rc) begin
      errors++;
      $display("FAIL discard_noresp: got %0d responses, required 0", resp_count - rc);
    end
  endtask

  task automatic test_alias();
    send(32'h400, 32'hA5A5A5A5, 1'b1, 1'b0, 4'd1, -1);
    send(32'h0,   32'h0,        1'b0, 1'b1, 4'd2, -1);
    send(32'h13,  32'h1,        1'b1, 1'b0, 4'd3, -1);
    send(32'h10,  32'h0,        1'b0, 1'b1, 4'd4, -1);
    idle_req();
    drain();
  endtask

  task automatic test_reset_mid();
    int rc;
    send(32'h10, 32'h0, 1'b0, 1'b1, 4'd9, -1);
    idle_req();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp !== '0 || resp_tag !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_state: got ready=%b resp=%h tag=%0d, required ready=1 resp=0 tag=0",
               req_ready, resp, resp_tag);
    end
    rc = resp_count;
    repeat (10) @(negedge clk);
    checks++;
    if (resp_count !== rc) begin
      errors++;
      $display("FAIL reset_mid_noresp: got %0d responses, required 0", resp_count - rc);
    end
    send(32'h20, 32'h0, 1'b0, 1'b1, 4'd10, 3);
    idle_req();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    req     = '0;
    req_tag = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_alias();
    test_flags();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
